oam_dma_controller: RTL

//  Sequences the OAM DMA (FF46) transfer: copies LENGTH bytes from {src,8'h00} to DST_BASE.

---
 rtl/oam_dma_controller.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/oam_dma_controller.sv
// OAM DMA sequencer and CPU/DMA arbiter for the single MMU access port.
// Optional HRAM pass-through during DMA: define DMA_HRAM_PASSTHRU_EN.
module oam_dma_controller #(
    parameter int          LENGTH     = 160,
    parameter logic [15:0] DST_BASE   = 16'hFE00,
    parameter logic [7:0]  BLOCK_FILL = 8'hFF
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iDmaWe,
    input  logic [7:0]  iDmaData,
    input  logic [15:0] iCpuAddr,
    input  logic        iCpuWe,
    input  logic [7:0]  iCpuData,
    input  logic        iCpuReadRequest,
    output logic [7:0]  oCpuData,
    output logic [15:0] oMemAddr,
    output logic        oMemWe,
    output logic [7:0]  oMemData,
    output logic        oMemReadRequest,
    input  logic [7:0]  iMemData,
    output logic        oDmaBusy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR
    } state_t;

    localparam logic [7:0] LAST = 8'(LENGTH - 1);

    state_t     state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] src_q, src_d;
    logic [7:0] latch_q, latch_d;
    logic       blk_rd_q, blk_rd_d;
    logic       busy_q, busy_d;
    logic       hold_q, hold_d;
    logic       hram;
    logic       stall;
    logic       active;

`ifdef DMA_HRAM_PASSTHRU_EN
    assign hram = (iCpuWe | iCpuReadRequest) &&
                  (iCpuAddr >= 16'hFF80) && (iCpuAddr <= 16'hFFFE);
`else
    assign hram = 1'b0;
`endif

    assign active = (state_q != S_IDLE);
    assign stall  = active && hram;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        src_d    = src_q;
        latch_d  = latch_q;
        hold_d   = hold_q;
        blk_rd_d = active && iCpuReadRequest && !stall;

        oMemAddr        = iCpuAddr;
        oMemWe          = iCpuWe;
        oMemData        = iCpuData;
        oMemReadRequest = iCpuReadRequest;
        if (active && !stall) begin
            oMemAddr        = 16'h0000;
            oMemWe          = 1'b0;
            oMemData        = 8'h00;
            oMemReadRequest = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
            end
            S_RD: begin
                if (!stall) begin
                    oMemAddr        = {src_q, idx_q};
                    oMemReadRequest = 1'b1;
                    state_d         = S_CAP;
                end
            end
            S_CAP: begin
                // The DMA read data is only valid on the first CAP cycle;
                // later (stretched) cycles carry CPU read data instead.
                if (!hold_q) latch_d = iMemData;
                if (stall) begin
                    hold_d = 1'b1;
                end else begin
                    hold_d  = 1'b0;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                if (!stall) begin
                    oMemAddr = DST_BASE + {8'h00, idx_q};
                    oMemData = latch_q;
                    oMemWe   = 1'b1;
                    if (idx_q == LAST) begin
                        idx_d   = 8'h00;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 8'h01;
                        state_d = S_RD;
                    end
                end
            end
            default: begin
            end
        endcase

        if (iDmaWe) begin
            src_d   = iDmaData;
            idx_d   = 8'h00;
            hold_d  = 1'b0;
            state_d = S_RD;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q  <= S_IDLE;
            idx_q    <= 8'h00;
            src_q    <= 8'h00;
            latch_q  <= 8'h00;
            blk_rd_q <= 1'b0;
            busy_q   <= 1'b0;
            hold_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            src_q    <= src_d;
            latch_q  <= latch_d;
            blk_rd_q <= blk_rd_d;
            busy_q   <= busy_d;
            hold_q   <= hold_d;
        end
    end

    assign oCpuData = blk_rd_q ? BLOCK_FILL : iMemData;
    assign oDmaBusy = busy_q;

endmodule
